// File: rtl/param_stream_buffer_if.sv
// Bus bundle for param_stream_buffer: word write port, burst read command and beat stream.
// Optional byte-strobe signal wr_strb exists only when BUF_WSTRB_EN is defined.
interface param_stream_buffer_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 128,
  parameter int LANES  = 4
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic                    wr_en;
  logic [ADDR_W-1:0]       wr_addr;
  logic [DATA_W-1:0]       wr_data;
`ifdef BUF_WSTRB_EN
  logic [DATA_W/8-1:0]     wr_strb;
`endif
  logic                    rd_start;
  logic [ADDR_W-1:0]       rd_base;
  logic [ADDR_W:0]         rd_len;
  logic                    rd_busy;
  logic                    rd_err;
  logic                    out_valid;
  logic                    out_ready;
  logic [LANES*DATA_W-1:0] out_data;
  logic [ADDR_W-1:0]       out_addr;
  logic                    out_last;

  // Master is the producer of writes/commands and the consumer of beats.
  modport master (
    output wr_en, wr_addr, wr_data,
`ifdef BUF_WSTRB_EN
    output wr_strb,
`endif
    output rd_start, rd_base, rd_len, out_ready,
    input  rd_busy, rd_err, out_valid, out_data, out_addr, out_last
  );

  modport slave (
    input  wr_en, wr_addr, wr_data,
`ifdef BUF_WSTRB_EN
    input  wr_strb,
`endif
    input  rd_start, rd_base, rd_len, out_ready,
    output rd_busy, rd_err, out_valid, out_data, out_addr, out_last
  );
endinterface

// File: rtl/param_stream_buffer.sv
// Word buffer with a random-access write port and a LANES-wide burst read streamer.
// Define BUF_WSTRB_EN to enable per-byte write strobes (wr_strb) with byte-merged forwarding.
module param_stream_buffer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 128,
  parameter int LANES  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  param_stream_buffer_if.slave  bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int BEAT_W = LANES * DATA_W;
  localparam logic [ADDR_W-1:0] LANE_STEP = ADDR_W'(LANES);
  localparam logic [ADDR_W:0]   LEN_ONE   = 1;

  typedef enum logic {IDLE, STREAM} state_t;

  state_t            state;
  logic [ADDR_W:0]   len;
  logic [ADDR_W:0]   beat_idx;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] load_addr;
  logic [ADDR_W-1:0] lane_addr;
  logic [DATA_W-1:0] lane_word;
  logic [BEAT_W-1:0] load_beat;

`ifdef BUF_WSTRB_EN
  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0]   old_word,
    input logic [DATA_W-1:0]   new_word,
    input logic [DATA_W/8-1:0] strb
  );
    logic [DATA_W-1:0] res;
    res = old_word;
    for (int i = 0; i < DATA_W / 8; i++) begin
      if (strb[i]) res[i*8 +: 8] = new_word[i*8 +: 8];
    end
    return res;
  endfunction
`endif

  // NOTE: the array is cleared by reset, so it maps to flops rather than a RAM macro;
  // that is the price of guaranteed all-zero contents after any reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (bus.wr_en) begin
`ifdef BUF_WSTRB_EN
      mem[bus.wr_addr] <= merge_bytes(mem[bus.wr_addr], bus.wr_data, bus.wr_strb);
`else
      mem[bus.wr_addr] <= bus.wr_data;
`endif
    end
  end

  // Beat about to be loaded: start address in IDLE, next beat in STREAM.
  // A same-cycle write to one of its lanes is forwarded so the beat sees it.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    load_beat = '0;
    lane_addr = '0;
    lane_word = '0;
    load_addr = (state == IDLE) ? bus.rd_base : bus.out_addr + LANE_STEP;
    for (int k = 0; k < LANES; k++) begin
      lane_addr = load_addr + ADDR_W'(k);
      lane_word = mem[lane_addr];
      if (bus.wr_en && (bus.wr_addr == lane_addr)) begin
`ifdef BUF_WSTRB_EN
        lane_word = merge_bytes(lane_word, bus.wr_data, bus.wr_strb);
`else
        lane_word = bus.wr_data;
`endif
      end
      load_beat[k*DATA_W +: DATA_W] = lane_word;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      len           <= '0;
      beat_idx      <= '0;
      bus.rd_busy   <= 1'b0;
      bus.rd_err    <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
      bus.out_data  <= '0;
      bus.out_addr  <= '0;
    end else begin
      bus.rd_err <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.rd_start) begin
            if (bus.rd_len == '0) begin
              bus.rd_err <= 1'b1;
            end else begin
              state         <= STREAM;
              len           <= bus.rd_len;
              beat_idx      <= '0;
              bus.rd_busy   <= 1'b1;
              bus.out_valid <= 1'b1;
              bus.out_data  <= load_beat;
              bus.out_addr  <= load_addr;
              bus.out_last  <= (bus.rd_len == LEN_ONE);
            end
          end
        end
        STREAM: begin
          // out_valid is always high here, so ready alone marks a transfer.
          if (bus.out_ready) begin
            if (bus.out_last) begin
              state         <= IDLE;
              bus.rd_busy   <= 1'b0;
              bus.out_valid <= 1'b0;
              bus.out_last  <= 1'b0;
              bus.out_data  <= '0;
              bus.out_addr  <= '0;
            end else begin
              beat_idx      <= beat_idx + LEN_ONE;
              bus.out_data  <= load_beat;
              bus.out_addr  <= load_addr;
              bus.out_last  <= ((beat_idx + LEN_ONE) == (len - LEN_ONE));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_param_stream_buffer.sv
// Directed bench for param_stream_buffer: vector table for burst/handshake behaviour
// plus hand sequences for forwarding, asynchronous reset and (with BUF_WSTRB_EN) byte strobes.
module tb_param_stream_buffer;
  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  param_stream_buffer_if #(.DATA_W(32), .DEPTH(128), .LANES(4)) bus ();

  param_stream_buffer #(.DATA_W(32), .DEPTH(128), .LANES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Outputs packed as {valid, busy, last, err, addr[6:0], data[127:0]}.
  typedef struct {
    logic         start;
    logic [6:0]   base;
    logic [7:0]   len;
    logic         ready;
    logic [138:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [138:0] outs(logic v, logic b, logic l, logic e,
                                        logic [6:0] a, logic [127:0] d);
    return {v, b, l, e, a, d};
  endfunction

  function automatic logic [138:0] cur();
    return {bus.out_valid, bus.rd_busy, bus.out_last, bus.rd_err, bus.out_addr, bus.out_data};
  endfunction

  // Beat expected after the mem[i] = 0x100 + i preload.
  function automatic logic [127:0] pre(int a);
    logic [127:0] r;
    for (int k = 0; k < 4; k++) r[k*32 +: 32] = 32'h100 + 32'((a + k) % 128);
    return r;
  endfunction

  function automatic void add(logic s, logic [6:0] b, logic [7:0] l, logic r, logic [138:0] e);
    vec_t v;
    v.start = s; v.base = b; v.len = l; v.ready = r; v.exp = e;
    vecs.push_back(v);
  endfunction

  task automatic check(string name, logic [138:0] act, logic [138:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vectors(int lo, int hi);
    for (int i = lo; i < hi; i++) begin
      bus.rd_start  = vecs[i].start;
      bus.rd_base   = vecs[i].base;
      bus.rd_len    = vecs[i].len;
      bus.out_ready = vecs[i].ready;
      tick();
      check($sformatf("vec%0d", i), cur(), vecs[i].exp);
    end
    bus.rd_start = 1'b0;
  endtask

  task automatic write(logic [6:0] a, logic [31:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset         = 1'b1;
    bus.wr_en     = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
`ifdef BUF_WSTRB_EN
    bus.wr_strb   = '1;
`endif
    bus.rd_start  = 1'b0;
    bus.rd_base   = '0;
    bus.rd_len    = '0;
    bus.out_ready = 1'b0;

    // Zero-memory burst (rows 0..2), then preloaded rows.
    add(1, 7'd0, 8'd2, 1, outs(1, 1, 0, 0, 7'd0, '0));
    add(0, 7'd0, 8'd0, 1, outs(1, 1, 1, 0, 7'd4, '0));
    add(0, 7'd0, 8'd0, 1, outs(0, 0, 0, 0, 7'd0, '0));
    // Wrapping single-beat burst.
    add(1, 7'd126, 8'd1, 0, outs(1, 1, 1, 0, 7'd126, pre(126)));
    add(0, 7'd0, 8'd0, 1, outs(0, 0, 0, 0, 7'd0, '0));
    // Back-pressure with stray rd_start in STREAM, then three sustained beats.
    add(1, 7'd8, 8'd3, 0, outs(1, 1, 0, 0, 7'd8, pre(8)));
    add(1, 7'd0, 8'd0, 0, outs(1, 1, 0, 0, 7'd8, pre(8)));
    add(1, 7'd40, 8'd5, 0, outs(1, 1, 0, 0, 7'd8, pre(8)));
    add(0, 7'd0, 8'd0, 0, outs(1, 1, 0, 0, 7'd8, pre(8)));
    add(0, 7'd0, 8'd0, 0, outs(1, 1, 0, 0, 7'd8, pre(8)));
    add(0, 7'd0, 8'd0, 1, outs(1, 1, 0, 0, 7'd12, pre(12)));
    add(0, 7'd0, 8'd0, 1, outs(1, 1, 1, 0, 7'd16, pre(16)));
    add(0, 7'd0, 8'd0, 1, outs(0, 0, 0, 0, 7'd0, '0));
    // Illegal length.
    add(1, 7'd3, 8'd0, 0, outs(0, 0, 0, 1, 7'd0, '0));
    add(0, 7'd0, 8'd0, 0, outs(0, 0, 0, 0, 7'd0, '0));
    // Beats crossing the top of the buffer.
    add(1, 7'd124, 8'd3, 1, outs(1, 1, 0, 0, 7'd124, pre(124)));
    add(0, 7'd0, 8'd0, 1, outs(1, 1, 0, 0, 7'd0, pre(0)));
    add(0, 7'd0, 8'd0, 1, outs(1, 1, 1, 0, 7'd4, pre(4)));
    add(0, 7'd0, 8'd0, 1, outs(0, 0, 0, 0, 7'd0, '0));

    tick();
    tick();
    check("reset_state", cur(), outs(0, 0, 0, 0, 7'd0, '0));
    reset = 1'b0;

    run_vectors(0, 3);

    for (int i = 0; i < 128; i++) begin
      write(7'(i), 32'h100 + 32'(i));
      tick();
    end
    bus.wr_en = 1'b0;

    run_vectors(3, vecs.size());

    // Write-first forwarding on the initial load, then write to a held beat.
    bus.rd_start = 1'b1; bus.rd_base = 7'd12; bus.rd_len = 8'd2; bus.out_ready = 1'b0;
    write(7'd13, 32'hDEADBEEF);
    tick();
    bus.rd_start = 1'b0;
    check("fwd_first_beat", cur(),
          outs(1, 1, 0, 0, 7'd12, {32'h10F, 32'h10E, 32'hDEADBEEF, 32'h10C}));
    write(7'd12, 32'h12345678);
    tick();
    check("held_beat_stable", cur(),
          outs(1, 1, 0, 0, 7'd12, {32'h10F, 32'h10E, 32'hDEADBEEF, 32'h10C}));
    write(7'd17, 32'hCAFEF00D);
    bus.out_ready = 1'b1;
    tick();
    bus.wr_en = 1'b0;
    check("fwd_next_beat", cur(),
          outs(1, 1, 1, 0, 7'd16, {32'h113, 32'h112, 32'hCAFEF00D, 32'h110}));
    tick();
    check("fwd_burst_end", cur(), outs(0, 0, 0, 0, 7'd0, '0));
    bus.rd_start = 1'b1; bus.rd_base = 7'd12; bus.rd_len = 8'd1;
    tick();
    bus.rd_start = 1'b0;
    check("held_write_landed", cur(),
          outs(1, 1, 1, 0, 7'd12, {32'h10F, 32'h10E, 32'hDEADBEEF, 32'h12345678}));
    tick();

    // Asynchronous reset on beat 1 of a 4-beat burst.
    bus.rd_start = 1'b1; bus.rd_base = 7'd0; bus.rd_len = 8'd4; bus.out_ready = 1'b1;
    tick();
    bus.rd_start = 1'b0;
    tick();
    check("pre_reset_beat1", cur(),
          outs(1, 1, 0, 0, 7'd4, {32'h107, 32'h106, 32'h105, 32'h104}));
    #1 reset = 1'b1;
    #1 check("async_reset_drop", cur(), outs(0, 0, 0, 0, 7'd0, '0));
    tick();
    reset = 1'b0;
    bus.rd_start = 1'b1; bus.rd_base = 7'd12; bus.rd_len = 8'd1; bus.out_ready = 1'b0;
    tick();
    bus.rd_start = 1'b0;
    check("mem_cleared", cur(), outs(1, 1, 1, 0, 7'd12, '0));
    bus.out_ready = 1'b1;
    tick();
    check("post_reset_idle", cur(), outs(0, 0, 0, 0, 7'd0, '0));

`ifdef BUF_WSTRB_EN
    // Byte strobes: full write, single-byte merge, then an all-zero strobe.
    write(7'd5, 32'h11223344); bus.wr_strb = 4'b1111;
    tick();
    write(7'd5, 32'hAABBCCDD); bus.wr_strb = 4'b0010;
    tick();
    write(7'd5, 32'hFFFFFFFF); bus.wr_strb = 4'b0000;
    tick();
    bus.wr_en = 1'b0; bus.wr_strb = 4'b1111;
    bus.rd_start = 1'b1; bus.rd_base = 7'd4; bus.rd_len = 8'd1; bus.out_ready = 1'b0;
    tick();
    bus.rd_start = 1'b0;
    check("strb_merge", cur(), outs(1, 1, 1, 0, 7'd4, {32'h0, 32'h0, 32'h1122CC44, 32'h0}));
    bus.out_ready = 1'b1;
    tick();
    // Strobed write forwarded into the loading beat, merged per byte.
    bus.rd_start = 1'b1; bus.rd_base = 7'd4; bus.rd_len = 8'd1; bus.out_ready = 1'b0;
    write(7'd5, 32'h000000EE); bus.wr_strb = 4'b0001;
    tick();
    bus.rd_start = 1'b0; bus.wr_en = 1'b0; bus.wr_strb = 4'b1111;
    check("strb_forward", cur(), outs(1, 1, 1, 0, 7'd4, {32'h0, 32'h0, 32'h1122CCEE, 32'h0}));
    bus.out_ready = 1'b1;
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/param_stream_buffer.md
Name: param_stream_buffer

Overview:
- Parametrised internal word buffer for the RV32I datapath: single-word random-access write port, plus a burst read engine.
- The read engine streams LANES consecutive words per beat over a valid/ready handshake.
- Replaces fixed-size, all-words-parallel output with a configurable depth/width and back-pressure-aware streaming readout.
- Sits between the core's store path and downstream consumers (accelerator / debug readout).

Parameters:
DATA_W, 32, word width in bits
DEPTH, 128, number of words; power of two, >= LANES
LANES, 4, words delivered per beat; power of two, divides DEPTH
ADDR_W, $clog2(DEPTH), derived localparam; not overridable

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
wr_en  in  1  write strobe
wr_addr  in  ADDR_W  write word address
wr_data  in  DATA_W  write data
rd_start  in  1  start burst (single-cycle pulse)
rd_base  in  ADDR_W  first word address of burst
rd_len  in  ADDR_W+1  burst length in beats; 0 is illegal
rd_busy  out  1  burst in progress
rd_err  out  1  one-cycle pulse: illegal rd_len at start
out_valid  out  1  beat valid
out_ready  in  1  consumer accepts beat
out_data  out  LANES*DATA_W  lane k at bits [k*DATA_W +: DATA_W]
out_addr  out  ADDR_W  address of lane 0 of current beat
out_last  out  1  current beat is final beat of burst

Behaviour:
- Reset (async, any time including mid-burst): all memory words = 0; FSM -> IDLE; rd_busy, rd_err, out_valid, out_last = 0; out_data, out_addr = 0. Burst is aborted, not resumed.
- Write: wr_en at posedge -> mem[wr_addr] <= wr_data. Writes are accepted in every state.
- FSM states: IDLE, STREAM.
- IDLE, rd_start=1, rd_len!=0:
  - Capture base and len.
  - Next cycle: STREAM, rd_busy=1, out_valid=1, beat 0 loaded.
  - Start-to-first-beat latency: 1 cycle.
- IDLE, rd_start=1, rd_len=0: stay IDLE; rd_err=1 for exactly the next cycle.
- rd_start in STREAM: ignored, no rd_err.
- Beat content: lane k = mem[(beat_addr + k) mod DEPTH]. Beat n has beat_addr = (base + n*LANES) mod DEPTH; out_addr = beat_addr. Addresses wrap silently.
- rd_len > DEPTH/LANES is legal; the burst re-reads wrapped words.
- Handshake:
  - Beat is transferred when out_valid & out_ready at posedge.
  - While out_valid & !out_ready: out_data, out_addr, out_last held stable.
  - Non-last transfer: next beat loaded at that edge; out_valid stays 1 (one beat per cycle sustained).
  - Last transfer: next cycle out_valid=0, out_last=0, rd_busy=0, out_data=0, FSM -> IDLE.
- out_last = 1 exactly when the current beat index = len-1.
- Write/load collision: a write in the same cycle a beat is loaded, targeting a lane of that beat, is forwarded (write-first). A write after load does not alter the held beat.
- out_data = 0 whenever out_valid = 0.
- Beat counter width: ADDR_W+1. No overflow is possible.

Optional Feature:
- Macro: BUF_WSTRB_EN.
- Defined:
  - Adds port wr_strb, in, DATA_W/8 bits.
  - Byte i of mem[wr_addr] is written only when wr_strb[i]=1; wr_en with wr_strb=0 leaves the word unchanged.
  - Forwarding merges per byte.
  - DATA_W must be a multiple of 8.
- Undefined: no wr_strb port; every write replaces the full word.

Test Plan:
- Reset, then start base=0, len=2, ready=1 -> cycle+1 beat0 = {0,0,0,0}, out_addr=0, out_last=0; cycle+2 beat1, out_last=1; cycle+3 out_valid=0, rd_busy=0.
- Write mem[i] = 32'h100+i for i=0..127; start base=126, len=1 -> lanes = {0x17E, 0x17F, 0x100, 0x101} (lane0 first), out_addr=126, out_last=1.
- Same preload; start base=8, len=3; ready low 5 cycles, then high -> beat0 (0x108..0x10B) stable all 5 cycles; then 3 beats on consecutive cycles at out_addr 8, 12, 16.
- Start with len=0 -> rd_err high exactly 1 cycle, out_valid stays 0; rd_start during STREAM ignored.
- Write mem[13] = 32'hDEADBEEF in the cycle beat base=12 loads -> lane1 = 0xDEADBEEF. Write mem[12] while beat held -> held lane0 unchanged.
- Assert reset mid-burst (beat 1 of 4) -> out_valid, rd_busy drop asynchronously; subsequent read shows all zeros. With BUF_WSTRB_EN: strb=4'b0010, data 0xAABBCCDD onto 0x11223344 -> 0x1122CC44.
